// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel responder backed by a byte-strobed internal RAM.
// One AW/W burst at a time; BRESP reports address, size, burst-type and WLAST faults.
module axi_wr_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_AW           = 10
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_MEM_AW-1:0]               dbg_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     dbg_rd_data,
  output logic [15:0]                       burst_cnt
);

  localparam int unsigned ID_W   = C_S_AXI_ID_WIDTH;
  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 1 << C_MEM_AW;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [1:0]        b_resp_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic              size_ok_q;
  logic [1:0]        burst_q;
  logic [8:0]        beat_q;
  logic              err_q;
  logic [15:0]       burst_cnt_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                aw_hs, w_hs, b_hs;
  logic                addr_oob, beat_oob, burst_bad, early_last;
  logic                beat_err, err_d, wr_en;
  logic [C_MEM_AW-1:0] word_idx;

  assign aw_hs = S_AXI_AWVALID & aw_ready_q;
  assign w_hs  = S_AXI_WVALID & w_ready_q;
  assign b_hs  = b_valid_q & S_AXI_BREADY;

  // Per-beat legality; address range is re-evaluated as the burst advances
  always_comb begin
    addr_oob   = (addr_q >> (LSB + C_MEM_AW)) != '0;
    word_idx   = addr_q[LSB +: C_MEM_AW];
    beat_oob   = beat_q > {1'b0, len_q};
    burst_bad  = burst_q == BURST_RSVD;
    early_last = S_AXI_WLAST & (beat_q < {1'b0, len_q});
    // WRAP (10) and reserved (11) both report SLVERR
    beat_err   = addr_oob | beat_oob | ~size_ok_q | burst_q[1] | early_last;
    err_d      = err_q | (w_hs & beat_err);
    wr_en      = w_hs & ~addr_oob & ~beat_oob & size_ok_q & ~burst_bad & ~ARESET;
  end

  // FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (aw_hs)               state_d = ST_DATA;
      ST_DATA: if (w_hs & S_AXI_WLAST)  state_d = ST_RESP;
      ST_RESP: if (b_hs)                state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state for single-cycle turnarounds
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      aw_ready_q <= state_d == ST_IDLE;
      w_ready_q  <= state_d == ST_DATA;
      b_valid_q  <= state_d == ST_RESP;
    end
  end

  // Burst context, beat tracking and response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_ok_q   <= 1'b0;
      burst_q     <= BURST_FIXED;
      beat_q      <= '0;
      err_q       <= 1'b0;
      b_resp_q    <= RESP_OKAY;
      burst_cnt_q <= '0;
    end else begin
      if (aw_hs) begin
        id_q      <= S_AXI_AWID;
        addr_q    <= S_AXI_AWADDR;
        len_q     <= S_AXI_AWLEN;
        size_ok_q <= S_AXI_AWSIZE == 3'(LSB);
        burst_q   <= S_AXI_AWBURST;
        beat_q    <= '0;
        err_q     <= 1'b0;
      end
      if (w_hs) begin
        err_q <= err_d;
        if (burst_q != BURST_FIXED) addr_q <= addr_q + ADDR_W'(STRB_W);
        // Saturate once past any legal LEN so overrun beats stay flagged
        if (!beat_q[8]) beat_q <= beat_q + 9'd1;
        if (S_AXI_WLAST) b_resp_q <= err_d ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_hs) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (S_AXI_WSTRB[i]) mem[word_idx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
      end
    end
  end

  // Side read port; a colliding write is seen one cycle later
  always_ff @(posedge ACLK) begin
    if (ARESET) rd_data_q <= '0;
    else        rd_data_q <= mem[dbg_rd_addr];
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = b_resp_q;
  assign S_AXI_BID     = id_q;
  assign burst_cnt     = burst_cnt_q;
  assign dbg_rd_data   = rd_data_q;

endmodule
